mio_bus_ctrl: RTL and testbench
===============================

# mio_bus_ctrl

Memory/IO bus controller sitting directly downstream of the multicycle CPU control unit. Accepts the CPU's MemRead/MemWrite/CPU_MIO request and address, decodes it to data RAM, GPIO or counter, inserts RAM wait states, and returns MIO_ready plus read data. MIO_ready is the signal the control unit waits on in its fetch state.

## Interface
- RAM_WAIT, 2: RAM read wait cycles, legal range 1..15.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- MemRead  in  1  read request, from control unit.
- MemWrite  in  1  write request, from control unit.
- CPU_MIO  in  1  request qualifier; a request exists only when CPU_MIO=1 and (MemRead or MemWrite).
- addr  in  32  byte address, held stable by requester until MIO_ready.
- data_from_cpu  in  32  write data, held stable until MIO_ready.
- data_to_cpu  out  32  registered read data.
- MIO_ready  out  1  one-cycle completion pulse.
- ram_addr  out  10  word address, equals addr[11:2], combinational.
- ram_we  out  1  RAM write strobe.
- ram_din  out  32  equals data_from_cpu.
- ram_dout  in  32  synchronous RAM read data.
- gpio_in  in  32  switch inputs.
- gpio_out  out  32  LED/output register.
- counter_we  out  1  counter load strobe.
- counter_din  out  32  equals data_from_cpu.
- counter_val  in  32  current counter value.

## Operation
- Address map:
  - RAM: addr[31:12]=0.
  - GPIO: addr[31:28]=4'hE.
  - COUNTER: addr[31:28]=4'hF.
  - Anything else: UNMAPPED.
- MemRead and MemWrite both high: treated as a write.
- FSM states IDLE, WAIT, DONE. Reset enters IDLE.
- IDLE, no request: stay in IDLE.
- IDLE with request:
  - RAM read: load wait counter with RAM_WAIT-1, go to WAIT.
  - All other requests go to DONE.
  - GPIO write: gpio_out <= data_from_cpu on this edge.
  - GPIO read: data_to_cpu <= gpio_in on this edge.
  - COUNTER read: data_to_cpu <= counter_val on this edge.
  - UNMAPPED read: data_to_cpu <= 0 on this edge.
  - UNMAPPED write: no side effect.
  - Latch the decoded target and the read/write type into registers.
- WAIT: decrement counter each cycle. When counter=0: data_to_cpu <= ram_dout, go to DONE.
- DONE:
  - MIO_ready=1.
  - ram_we=1 if latched target is RAM write.
  - counter_we=1 if latched target is COUNTER write.
  - Always go to IDLE next.
- Strobes: ram_we, counter_we and MIO_ready are high only in DONE.
- data_to_cpu holds its value until the next read completes. Writes never change it.
- Requester rule: drop the request in the cycle after MIO_ready. A request still present in IDLE is a new transaction.
- Reset values: data_to_cpu=0, gpio_out=0, MIO_ready=0, ram_we=0, counter_we=0, state=IDLE, wait counter=0.
- Reset low mid-transaction: abort to IDLE. No MIO_ready, ram_we or counter_we is issued for the aborted access.

## Timing
- Cycle 0 is the IDLE cycle where the request is first seen.
- RAM read: MIO_ready in cycle RAM_WAIT+1. Data valid in the same cycle and held after.
- All writes and non-RAM reads: MIO_ready in cycle 1.
- GPIO write: gpio_out visible from cycle 1.
- Minimum spacing is one IDLE cycle between back-to-back transactions, so throughput is one access per 2 cycles (non-RAM-read).
- No combinational path from any input to MIO_ready, ram_we or counter_we.

## Test plan
- RAM write then read, RAM_WAIT=2:
  - Write addr=0x0000_0010, data=0xDEADBEEF: ram_we=1 with ram_addr=4 in cycle 1, MIO_ready in cycle 1.
  - Read same address: MIO_ready in cycle 3, data_to_cpu=0xDEADBEEF.
- GPIO write then read:
  - Write 0xE000_0000 with 0x0000_00A5: gpio_out=0xA5 from cycle 1, ram_we stays 0.
  - Read with gpio_in=0x1234: data_to_cpu=0x1234, MIO_ready in cycle 1.
- Counter:
  - Write 0xF000_0004 with 100: counter_we=1 for exactly 1 cycle, counter_din=100.
  - Read with counter_val=0x55: data_to_cpu=0x55.
- Unmapped address 0x8000_0000:
  - Read: data_to_cpu=0, MIO_ready in cycle 1.
  - Write: no strobe, gpio_out unchanged.
- Held request (CPU_MIO kept high 6 cycles, non-RAM read): MIO_ready pulses in cycles 1 and 3.
- Reset during RAM WAIT: reset low in cycle 1 of a read:
  - No MIO_ready.
  - state=IDLE, data_to_cpu=0, gpio_out=0 on release.
  - Next read completes normally.

Source files
------------

// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller: decodes CPU requests to RAM, GPIO or counter and returns MIO_ready.
// Latency: RAM reads complete in RAM_WAIT+1 cycles; all other accesses complete in 1 cycle.
// Backpressure: the requester holds addr/data until MIO_ready; one IDLE cycle separates accesses.
module mio_bus_ctrl #(
  // RAM read wait cycles; meaningful range is 1..15 (4-bit wait counter)
  parameter int unsigned RAM_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        CPU_MIO,
  input  logic [31:0] addr,
  input  logic [31:0] data_from_cpu,
  output logic [31:0] data_to_cpu,
  output logic        MIO_ready,
  output logic [9:0]  ram_addr,
  output logic        ram_we,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out,
  output logic        counter_we,
  output logic [31:0] counter_din,
  input  logic [31:0] counter_val
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    T_RAM  = 2'd0,
    T_GPIO = 2'd1,
    T_CNT  = 2'd2,
    T_NONE = 2'd3
  } tgt_t;

  localparam logic [3:0] WAIT_LOAD = 4'(RAM_WAIT - 1);

  state_t      state_q, state_d;
  tgt_t        tgt_q, tgt_dec;
  logic        wr_q;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        req, is_wr, is_rd;
  logic        latch_req;
  logic        data_load;
  logic [31:0] data_d;
  logic        gpio_load;
  logic        unused_addr_bits;

  // Byte-offset bits are irrelevant for a word-wide bus.
  assign unused_addr_bits = ^addr[1:0];

  // Pass-through paths to the RAM and counter.
  assign ram_addr    = addr[11:2];
  assign ram_din     = data_from_cpu;
  assign counter_din = data_from_cpu;

  // Request qualification; simultaneous read and write counts as a write.
  assign req   = CPU_MIO & (MemRead | MemWrite);
  assign is_wr = MemWrite;
  assign is_rd = MemRead & ~MemWrite;

  // Address decode into a target.
  always_comb begin
    tgt_dec = T_NONE;
    if (addr[31:12] == 20'd0) begin
      tgt_dec = T_RAM;
    end else if (addr[31:28] == 4'hE) begin
      tgt_dec = T_GPIO;
    end else if (addr[31:28] == 4'hF) begin
      tgt_dec = T_CNT;
    end
  end

  // Next-state, side-effect selection and registered-only strobes.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    latch_req  = 1'b0;
    data_load  = 1'b0;
    data_d     = data_to_cpu;
    gpio_load  = 1'b0;
    MIO_ready  = 1'b0;
    ram_we     = 1'b0;
    counter_we = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          latch_req = 1'b1;
          if (is_rd && tgt_dec == T_RAM) begin
            wait_cnt_d = WAIT_LOAD;
            state_d    = S_WAIT;
          end else begin
            state_d = S_DONE;
          end
          if (is_rd) begin
            case (tgt_dec)
              T_GPIO:  begin data_load = 1'b1; data_d = gpio_in;     end
              T_CNT:   begin data_load = 1'b1; data_d = counter_val; end
              T_NONE:  begin data_load = 1'b1; data_d = 32'd0;       end
              default: data_load = 1'b0;
            endcase
          end
          if (is_wr && tgt_dec == T_GPIO) begin
            gpio_load = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          data_load = 1'b1;
          data_d    = ram_dout;
          state_d   = S_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        // Strobes depend only on registered state so no input reaches them.
        MIO_ready  = 1'b1;
        ram_we     = wr_q && (tgt_q == T_RAM);
        counter_we = wr_q && (tgt_q == T_CNT);
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, wait counter and latched request attributes; reset aborts any access.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 4'd0;
      tgt_q      <= T_NONE;
      wr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (latch_req) begin
        tgt_q <= tgt_dec;
        wr_q  <= is_wr;
      end
    end
  end

  // Read data register: updated only when a read completes, held otherwise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_to_cpu <= 32'd0;
    end else if (data_load) begin
      data_to_cpu <= data_d;
    end
  end

  // GPIO output register, written on the accepting edge of a GPIO write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      gpio_out <= 32'd0;
    end else if (gpio_load) begin
      gpio_out <= data_from_cpu;
    end
  end

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Testbench for mio_bus_ctrl with a synchronous RAM model and a latency/data scoreboard.
// Inputs are driven and outputs sampled on the falling clock edge.
// Every wait on MIO_ready is bounded; a timeout shows up as a latency of -1.
module tb_mio_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic        CPU_MIO = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] data_from_cpu = 32'd0;
  logic [31:0] data_to_cpu;
  logic        MIO_ready;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic [31:0] gpio_in = 32'd0;
  logic [31:0] gpio_out;
  logic        counter_we;
  logic [31:0] counter_din;
  logic [31:0] counter_val = 32'd0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          lat;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  logic [31:0] mem [0:1023];

  always #5 clk = ~clk;

  mio_bus_ctrl #(.RAM_WAIT(2)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .CPU_MIO(CPU_MIO), .addr(addr), .data_from_cpu(data_from_cpu),
    .data_to_cpu(data_to_cpu), .MIO_ready(MIO_ready), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .counter_we(counter_we),
    .counter_din(counter_din), .counter_val(counter_val)
  );

  // Synchronous single-port RAM (read-before-write)
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
  end
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // Driver/monitor: issues one request, follows it to MIO_ready plus one trailing cycle.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output logic [31:0] dout,
                         output int rwe_n, output int cwe_n, output logic [9:0] we_addr,
                         output logic [31:0] we_din, output logic [31:0] gpio_c1);
    lat = -1; dout = 32'hX; rwe_n = 0; cwe_n = 0;
    we_addr = 10'h3FF; we_din = 32'hX; gpio_c1 = 32'hX;
    @(negedge clk);
    MemRead = rd; MemWrite = wr; CPU_MIO = 1'b1; addr = a; data_from_cpu = d;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) gpio_c1 = gpio_out;
      if (ram_we) begin rwe_n++; we_addr = ram_addr; end
      if (counter_we) begin cwe_n++; we_din = counter_din; end
      if (MIO_ready) begin lat = c; dout = data_to_cpu; break; end
    end
    CPU_MIO = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    if (ram_we) rwe_n++;
    if (counter_we) cwe_n++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({MIO_ready, ram_we, counter_we} !== 3'b000) begin
      failures++; $display("FAIL reset_strobes got=%b want=000", {MIO_ready, ram_we, counter_we});
    end
    checks++;
    if (data_to_cpu !== 32'd0) begin
      failures++; $display("FAIL reset_data got=%h want=0", data_to_cpu);
    end
    checks++;
    if (gpio_out !== 32'd0) begin
      failures++; $display("FAIL reset_gpio got=%h want=0", gpio_out);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ram();
    int lat, rwe_n, cwe_n; logic [31:0] dout, wdin, g1; logic [9:0] wa; exp_t e;
    sb.push_back('{lat: 1, data: 32'h0});
    run_txn(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, lat, dout, rwe_n, cwe_n, wa, wdin, g1);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) begin failures++; $display("FAIL ram_wr_latency got=%0d want=%0d", lat, e.lat); end
    checks++;
    if (rwe_n !== 1 || wa !== 10'd4) begin
      failures++; $display("FAIL ram_we_pulse count=%0d addr=%0d want count=1 addr=4", rwe_n, wa);
    end
    sb.push_back('{lat: 3, data: 32'hDEAD_BEEF});
    run_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, lat, dout, rwe_n, cwe_n, wa, wdin, g1);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) begin failures++; $display("FAIL ram_rd_latency got=%0d want=%0d", lat, e.lat); end
    checks++;
    if (dout !== e.data) begin failures++; $display("FAIL ram_rd_data got=%h want=%h", dout, e.data); end
    checks++;
    if (data_to_cpu !== e.data || rwe_n !== 0) begin
      failures++; $display("FAIL ram_rd_hold data=%h we=%0d want data=%h we=0", data_to_cpu, rwe_n, e.data);
    end
  endtask

  task automatic test_gpio();
    int lat, rwe_n, cwe_n; logic [31:0] dout, wdin, g1; logic [9:0] wa; exp_t e;
    sb.push_back('{lat: 1, data: 32'h0000_00A5});
    run_txn(1'b0, 1'b1, 32'hE000_0000, 32'h0000_00A5, lat, dout, rwe_n, cwe_n, wa, wdin, g1);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || g1 !== e.data) begin
      failures++; $display("FAIL gpio_wr lat=%0d gpio_c1=%h want lat=%0d gpio=%h", lat, g1, e.lat, e.data);
    end
    checks++;
    if (rwe_n !== 0 || cwe_n !== 0 || data_to_cpu !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL gpio_wr_side ram_we=%0d cnt_we=%0d data=%h want 0 0 deadbeef", rwe_n, cwe_n, data_to_cpu);
    end
    gpio_in = 32'h0000_1234;
    sb.push_back('{lat: 1, data: 32'h0000_1234});
    run_txn(1'b1, 1'b0, 32'hE000_0000, 32'h0, lat, dout, rwe_n, cwe_n, wa, wdin, g1);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || dout !== e.data) begin
      failures++; $display("FAIL gpio_rd lat=%0d data=%h want lat=%0d data=%h", lat, dout, e.lat, e.data);
    end
  endtask

  task automatic test_counter();
    int lat, rwe_n, cwe_n; logic [31:0] dout, wdin, g1; logic [9:0] wa; exp_t e;
    sb.push_back('{lat: 1, data: 32'd100});
    run_txn(1'b1, 1'b1, 32'hF000_0004, 32'd100, lat, dout, rwe_n, cwe_n, wa, wdin, g1);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || cwe_n !== 1 || wdin !== e.data) begin
      failures++; $display("FAIL cnt_wr lat=%0d pulses=%0d din=%0d want lat=1 pulses=1 din=%0d", lat, cwe_n, wdin, e.data);
    end
    counter_val = 32'h55;
    sb.push_back('{lat: 1, data: 32'h55});
    run_txn(1'b1, 1'b0, 32'hF000_0004, 32'h0, lat, dout, rwe_n, cwe_n, wa, wdin, g1);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || dout !== e.data || cwe_n !== 0) begin
      failures++; $display("FAIL cnt_rd lat=%0d data=%h we=%0d want lat=1 data=%h we=0", lat, dout, cwe_n, e.data);
    end
  endtask

  task automatic test_unmapped();
    int lat, rwe_n, cwe_n; logic [31:0] dout, wdin, g1; logic [9:0] wa; exp_t e;
    sb.push_back('{lat: 1, data: 32'h0});
    run_txn(1'b1, 1'b0, 32'h8000_0000, 32'h0, lat, dout, rwe_n, cwe_n, wa, wdin, g1);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || dout !== e.data) begin
      failures++; $display("FAIL unmapped_rd lat=%0d data=%h want lat=1 data=0", lat, dout);
    end
    run_txn(1'b0, 1'b1, 32'h8000_0000, 32'h0000_0077, lat, dout, rwe_n, cwe_n, wa, wdin, g1);
    checks++;
    if (lat !== 1 || rwe_n !== 0 || cwe_n !== 0 || gpio_out !== 32'h0000_00A5) begin
      failures++; $display("FAIL unmapped_wr lat=%0d ram_we=%0d cnt_we=%0d gpio=%h want 1 0 0 a5", lat, rwe_n, cwe_n, gpio_out);
    end
  endtask

  task automatic test_held_request();
    logic [5:1] obs;
    logic [5:1] want;
    want = 5'b00101;
    gpio_in = 32'h0000_CAFE;
    @(negedge clk);
    MemRead = 1'b1; CPU_MIO = 1'b1; addr = 32'hE000_0008;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      obs[c] = MIO_ready;
      if (c == 3) begin CPU_MIO = 1'b0; MemRead = 1'b0; end
    end
    checks++;
    if (obs !== want) begin
      failures++; $display("FAIL held_ready_pattern got=%b want=%b (cycles 5..1)", obs, want);
    end
    checks++;
    if (data_to_cpu !== 32'h0000_CAFE) begin
      failures++; $display("FAIL held_data got=%h want=0000cafe", data_to_cpu);
    end
  endtask

  task automatic test_reset_in_wait();
    int lat, rwe_n, cwe_n, stray; logic [31:0] dout, wdin, g1; logic [9:0] wa; exp_t e;
    stray = 0;
    @(negedge clk);
    MemRead = 1'b1; CPU_MIO = 1'b1; addr = 32'h0000_0010;
    @(negedge clk);
    reset = 1'b0;
    CPU_MIO = 1'b0; MemRead = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (MIO_ready || ram_we || counter_we) stray++;
    end
    reset = 1'b1;
    checks++;
    if (stray !== 0) begin failures++; $display("FAIL abort_strobes got=%0d want=0", stray); end
    checks++;
    if (data_to_cpu !== 32'd0 || gpio_out !== 32'd0) begin
      failures++; $display("FAIL abort_regs data=%h gpio=%h want 0 0", data_to_cpu, gpio_out);
    end
    sb.push_back('{lat: 3, data: 32'hDEAD_BEEF});
    run_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, lat, dout, rwe_n, cwe_n, wa, wdin, g1);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || dout !== e.data) begin
      failures++; $display("FAIL after_abort_rd lat=%0d data=%h want lat=%0d data=%h", lat, dout, e.lat, e.data);
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_gpio();
    test_counter();
    test_unmapped();
    test_held_request();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
